// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte-lane writes,
// registered reads, write-first bypass and range checking.
module reg_file_2r1w #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [WIDTH-1:0]      WrData,
  input  logic [WIDTH/8-1:0]    WrByteEn,
  input  logic                  RdEnA,
  input  logic [ADDR_WIDTH-1:0] RdAddrA,
  output logic [WIDTH-1:0]      RdDataA,
  output logic                  RdValidA,
  input  logic                  RdEnB,
  input  logic [ADDR_WIDTH-1:0] RdAddrB,
  output logic [WIDTH-1:0]      RdDataB,
  output logic                  RdValidB,
  output logic                  AddrErr
);

  localparam int NB  = WIDTH / 8;
  localparam int IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wrIn, aIn, bIn, wrActive;
  logic [IDX-1:0]   wrIdx, aIdx, bIdx;
  logic [WIDTH-1:0] wrMask;
  logic [WIDTH-1:0] rawA, rawB, nextA, nextB;
  logic             errNext;

  assign wrIn  = {1'b0, WrAddr}  < DEPTH_L;
  assign aIn   = {1'b0, RdAddrA} < DEPTH_L;
  assign bIn   = {1'b0, RdAddrB} < DEPTH_L;
  assign wrIdx = WrAddr[IDX-1:0];
  assign aIdx  = RdAddrA[IDX-1:0];
  assign bIdx  = RdAddrB[IDX-1:0];

  assign wrActive = WrEn && wrIn;

  always_comb begin
    wrMask = '0;
    for (int i = 0; i < NB; i++) begin
      wrMask[8*i +: 8] = {8{WrByteEn[i] & wrActive}};
    end
  end

  // Lookup is qualified by range so a non-power-of-two depth never
  // indexes past the array.
  always_comb begin
    rawA = '0;
    rawB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (aIn && aIdx == IDX'(i)) rawA = mem[i];
      if (bIn && bIdx == IDX'(i)) rawB = mem[i];
    end
  end

  always_comb begin
    nextA = rawA;
    nextB = rawB;
    if (aIn && RdAddrA == WrAddr) begin
      nextA = (rawA & ~wrMask) | (WrData & wrMask);
    end
    if (bIn && RdAddrB == WrAddr) begin
      nextB = (rawB & ~wrMask) | (WrData & wrMask);
    end
  end

  assign errNext = (WrEn && (|WrByteEn) && !wrIn)
                || (RdEnA && !aIn)
                || (RdEnB && !bIn);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wrActive && wrIdx == IDX'(i)) begin
          mem[i] <= (mem[i] & ~wrMask) | (WrData & wrMask);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      RdDataA  <= '0;
      RdDataB  <= '0;
      RdValidA <= 1'b0;
      RdValidB <= 1'b0;
      AddrErr  <= 1'b0;
    end else begin
      RdValidA <= RdEnA;
      RdValidB <= RdEnB;
      AddrErr  <= errNext;
      if (RdEnA) RdDataA <= nextA;
      if (RdEnB) RdDataB <= nextB;
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: expected read data is queued
// at issue and popped when the DUT raises its valid strobe.
module tb_reg_file_2r1w;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          WrEn = 1'b0;
  logic [AW-1:0] WrAddr = '0;
  logic [W-1:0]  WrData = '0;
  logic [1:0]    WrByteEn = '0;
  logic          RdEnA = 1'b0;
  logic [AW-1:0] RdAddrA = '0;
  logic [W-1:0]  RdDataA;
  logic          RdValidA;
  logic          RdEnB = 1'b0;
  logic [AW-1:0] RdAddrB = '0;
  logic [W-1:0]  RdDataB;
  logic          RdValidB;
  logic          AddrErr;

  reg_file_2r1w #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrByteEn(WrByteEn),
    .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdDataA(RdDataA), .RdValidA(RdValidA),
    .RdEnB(RdEnB), .RdAddrB(RdAddrB), .RdDataB(RdDataB), .RdValidB(RdValidB),
    .AddrErr(AddrErr)
  );

  always #5 CLK = ~CLK;

  int nRun  = 0;
  int nFail = 0;

  logic [W-1:0] model [D];
  logic [W-1:0] qA [$];
  logic [W-1:0] qB [$];
  logic         expVA, expVB, expErr;
  logic [W-1:0] lastA = '0;
  logic [W-1:0] lastB = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nRun++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] laneMask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [W-1:0] expRead(input logic [AW-1:0] a);
    logic [W-1:0] v;
    logic [W-1:0] m;
    if (a >= AW'(D)) return '0;
    v = model[a[2:0]];
    if (WrEn && WrAddr == a) begin
      m = laneMask(WrByteEn);
      v = (v & ~m) | (WrData & m);
    end
    return v;
  endfunction

  task automatic idle();
    WrEn  = 1'b0;
    RdEnA = 1'b0;
    RdEnB = 1'b0;
    WrByteEn = 2'b00;
  endtask

  task automatic tick();
    logic [W-1:0] m;
    logic [W-1:0] e;
    logic         doWr;
    logic [2:0]   wa;
    if (!RST) begin
      expVA = 1'b0;
      expVB = 1'b0;
      expErr = 1'b0;
    end else begin
      expVA = RdEnA;
      expVB = RdEnB;
      if (RdEnA) qA.push_back(expRead(RdAddrA));
      if (RdEnB) qB.push_back(expRead(RdAddrB));
      expErr = (WrEn && WrByteEn != 2'b00 && WrAddr >= AW'(D))
            || (RdEnA && RdAddrA >= AW'(D))
            || (RdEnB && RdAddrB >= AW'(D));
    end
    doWr = RST && WrEn && WrAddr < AW'(D);
    wa   = WrAddr[2:0];
    m    = laneMask(WrByteEn);
    @(posedge CLK);
    if (!RST) begin
      for (int i = 0; i < D; i++) model[i] = '0;
      lastA = '0;
      lastB = '0;
    end else if (doWr) begin
      model[wa] = (model[wa] & ~m) | (WrData & m);
    end
    #1;
    chk("validA", 32'(RdValidA), 32'(expVA));
    chk("validB", 32'(RdValidB), 32'(expVB));
    chk("addrErr", 32'(AddrErr), 32'(expErr));
    if (RdValidA) begin
      if (qA.size() == 0) chk("qA_empty", 32'(RdDataA), 32'hDEAD_BEEF);
      else begin
        e = qA.pop_front();
        chk("dataA", 32'(RdDataA), 32'(e));
        lastA = e;
      end
    end else chk("holdA", 32'(RdDataA), 32'(lastA));
    if (RdValidB) begin
      if (qB.size() == 0) chk("qB_empty", 32'(RdDataB), 32'hDEAD_BEEF);
      else begin
        e = qB.pop_front();
        chk("dataB", 32'(RdDataB), 32'(e));
        lastB = e;
      end
    end else chk("holdB", 32'(RdDataB), 32'(lastB));
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d,
                    input logic [1:0] be);
    WrEn = 1'b1;
    WrAddr = a;
    WrData = d;
    WrByteEn = be;
  endtask

  task automatic rdA(input logic [AW-1:0] a);
    RdEnA = 1'b1;
    RdAddrA = a;
  endtask

  task automatic rdB(input logic [AW-1:0] a);
    RdEnB = 1'b1;
    RdAddrB = a;
  endtask

  initial begin
    for (int i = 0; i < D; i++) model[i] = '0;
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();

    // reset clears the array
    for (int i = 0; i < D; i++) begin
      wr(AW'(i), 16'hFFFF, 2'b11);
      tick();
    end
    RST = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < D; i++) begin
      rdA(AW'(i));
      tick();
      chk("rstData", 32'(RdDataA), 32'h0);
    end

    // fill and dual read
    wr(0, 16'hE38A, 2'b11);
    tick();
    wr(7, 16'hCCCC, 2'b11);
    tick();
    rdA(0);
    rdB(7);
    tick();

    // byte lanes
    wr(3, 16'hAAAA, 2'b11);
    tick();
    wr(3, 16'h1234, 2'b01);
    tick();
    rdA(3);
    tick();
    chk("lane01", 32'(RdDataA), 32'hAA34);
    wr(3, 16'h5600, 2'b10);
    tick();
    rdB(3);
    tick();
    chk("lane10", 32'(RdDataB), 32'h5634);

    // write-first bypass on both ports
    wr(2, 16'hFF00, 2'b11);
    tick();
    wr(2, 16'h0F0F, 2'b10);
    rdA(2);
    rdB(2);
    tick();
    chk("bypA", 32'(RdDataA), 32'h0F00);
    chk("bypB", 32'(RdDataB), 32'h0F00);

    // out-of-range write dropped, array intact
    wr(9, 16'hBEEF, 2'b11);
    tick();
    tick();
    for (int i = 0; i < D; i += 2) begin
      rdA(AW'(i));
      rdB(AW'(i + 1));
      tick();
    end
    wr(9, 16'hBEEF, 2'b00);
    tick();
    rdA(200);
    tick();
    chk("oorData", 32'(RdDataA), 32'h0);
    tick();
    rdB(8);
    rdA(255);
    tick();

    // reset beats a concurrent write and read
    wr(1, 16'h1111, 2'b11);
    rdA(1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    rdA(1);
    tick();
    chk("rstWr", 32'(RdDataA), 32'h0);

    // read data holds while idle
    wr(5, 16'hCCCC, 2'b11);
    tick();
    rdA(5);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 32'(RdDataA), 32'hCCCC);
    end

    // random traffic against the model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr(AW'($urandom_range(0, 10)), W'($urandom), 2'($urandom));
      if ($urandom_range(0, 1) == 1) rdA(AW'($urandom_range(0, 10)));
      if ($urandom_range(0, 1) == 1) rdB(AW'($urandom_range(0, 10)));
      tick();
    end

    chk("qA_left", 32'(qA.size()), 32'h0);
    chk("qB_left", 32'(qB.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised two-read/one-write register file: the next generation of the 8 x 16 register file, generalised in width and depth. It adds byte-lane write enables, two independent registered read ports with valid strobes, write-to-read bypass and out-of-range address detection. It sits between the control path and the datapath as the shared configuration/scratch store.

## Interface
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- ADDR_WIDTH, 8, address bus width.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-low; sampled on the rising CLK edge.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  WIDTH  write data.
- WrByteEn  in  WIDTH/8  byte-lane enables; bit i covers WrData[8i+7:8i].
- RdEnA  in  1  read request, port A.
- RdAddrA  in  ADDR_WIDTH  read address, port A.
- RdDataA  out  WIDTH  registered read data, port A.
- RdValidA  out  1  port A data valid strobe.
- RdEnB, RdAddrB, RdDataB, RdValidB: identical to port A, for port B.
- AddrErr  out  1  one-cycle pulse on any out-of-range access.

## Operation
- Storage: DEPTH x WIDTH flops; no memory macro.
- Write: when WrEn=1 and WrAddr<DEPTH, each byte lane i with WrByteEn[i]=1 is updated from WrData; lanes with WrByteEn[i]=0 keep their value. WrEn=1 with WrByteEn=0 is a legal no-op (no error).
- Read (each port independently): when RdEn=1 and RdAddr<DEPTH, RdData loads entry RdAddr and RdValid=1 the next cycle. When RdEn=0, RdData holds its last value and RdValid=0.
- Bypass (write-first): a read and a write to the same in-range address in the same cycle return the merged value: enabled lanes from WrData, other lanes from the stored entry. Applies to A and B independently, including both ports reading the written address.
- Both ports may read the same address in the same cycle; both return identical data.
- Out-of-range (address ≥ DEPTH): a write is dropped and the array is unchanged. A read loads RdData=0 with RdValid=1. AddrErr=1 the next cycle if any enabled access (WrEn with any byte enabled, RdEnA or RdEnB) was out of range; it stays 1 for one cycle per offending cycle.
- Simultaneous WrEn and RdEn are always permitted; there is no arbitration and no stall.

## Timing
- Write latency: the value is visible to a non-bypassed read issued the cycle after the write edge.
- Read latency: 1 cycle (address sampled at edge N; data and RdValid are valid after edge N, during cycle N+1).
- Reset (RST=0 at a rising edge): all entries, RdDataA/B, RdValidA/B and AddrErr become 0 at that edge. Reset takes priority over WrEn and RdEn in the same cycle; a write or read presented during reset is discarded.
- First cycle after RST returns to 1: all reads return 0 until written.
- No combinational path from any input to any output.

## Test plan
- Reset: write 0xFFFF to all 8 entries, pulse RST=0 for one edge, then read addresses 0..7 on port A -> every RdDataA=0x0000, RdValidA=1, AddrErr=0.
- Fill and dual-read: write 0xE38A to addr 0 and 0xCCCC to addr 7 (WrByteEn=2'b11), then RdAddrA=0 and RdAddrB=7 in the same cycle -> next cycle RdDataA=0xE38A, RdDataB=0xCCCC, both valid.
- Byte lanes: addr 3 holds 0xAAAA; write 0x1234 with WrByteEn=2'b01 -> read gives 0xAA34. Then write 0x5600 with WrByteEn=2'b10 -> read gives 0x5634.
- Bypass: addr 2 holds 0xFF00; in one cycle write 0x0F0F with WrByteEn=2'b10 and read addr 2 on A and B -> both return 0x0F00 the next cycle.
- Out of range (DEPTH=8): WrEn to addr 9 with 0xBEEF -> AddrErr pulses one cycle, and entries 0..7 are unchanged. RdEnA addr 200 -> RdDataA=0, RdValidA=1, AddrErr=1 for exactly one cycle.
- Reset mid-operation and hold: RST=0 on the same edge as a write of 0x1111 to addr 1 and a read on A -> addr 1 reads 0 afterwards, RdValidA=0. With RdEn=0 for 3 cycles after a read of 0xCCCC, RdDataA stays 0xCCCC and RdValidA=0.
